// File: rtl/crc_checker.sv
// Receive-side CRC checker: recomputes an MSB-first CRC over a frame of words and
// compares it to the transmitted CRC. Optional error counter via CRC_CHECKER_ERRCNT_EN.
module crc_checker #(
   parameter int CRC_WIDTH = 8,
   parameter int DWIDTH    = 16,
   parameter int LEN_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic                 startIn,
   input  logic [LEN_WIDTH-1:0] frameLen,
   input  logic [CRC_WIDTH-1:0] GenPoly,
   input  logic                 dataValid,
   input  logic [DWIDTH-1:0]    dataIn,
   output logic                 dataReady,
   input  logic                 crcValid,
   input  logic [CRC_WIDTH-1:0] crcIn,
   output logic                 crcReady,
   output logic                 busy,
   output logic                 checkDone,
   output logic                 crcErr,
`ifdef CRC_CHECKER_ERRCNT_EN
   output logic [15:0]          errCnt,
   output logic [CRC_WIDTH-1:0] crcCalc
`else
   output logic [CRC_WIDTH-1:0] crcCalc
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_CRC  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // One full data word folded into the running CRC, most significant bit first.
   function automatic logic [CRC_WIDTH-1:0] crc_word(
      input logic [CRC_WIDTH-1:0] crc_in,
      input logic [DWIDTH-1:0]    d,
      input logic [CRC_WIDTH-1:0] poly
   );
      logic [CRC_WIDTH-1:0] c;
      logic                 fb;
      c = crc_in;
      for (int b = DWIDTH - 1; b >= 0; b--) begin
         fb = c[CRC_WIDTH-1] ^ d[b];
         c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? poly : {CRC_WIDTH{1'b0}});
      end
      return c;
   endfunction

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CRC_WIDTH-1:0] r_poly;
   logic [LEN_WIDTH-1:0] r_cnt;
   logic [CRC_WIDTH-1:0] r_crc;
   logic                 r_err;
   logic                 r_data_ready;
   logic                 r_crc_ready;
   logic                 r_busy;
   logic                 r_done;
   logic                 w_start;
   logic                 w_data_acc;
   logic                 w_crc_acc;
   logic                 w_mismatch;

   assign w_start    = startIn && (r_state == S_IDLE);
   assign w_data_acc = dataValid && r_data_ready;
   assign w_crc_acc  = crcValid && r_crc_ready;
   assign w_mismatch = (crcIn != r_crc);

   // Next-state decode; ready flags are registered copies of the next state.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = (frameLen == {LEN_WIDTH{1'b0}}) ? S_CRC : S_DATA;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DATA: begin
            if (w_data_acc && (r_cnt == LEN_WIDTH'(1))) begin
               w_state_nxt = S_CRC;
            end else begin
               w_state_nxt = S_DATA;
            end
         end
         S_CRC: begin
            if (w_crc_acc) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_CRC;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register and registered handshake/status outputs.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state      <= S_IDLE;
         r_data_ready <= 1'b0;
         r_crc_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_data_ready <= (w_state_nxt == S_DATA);
         r_crc_ready  <= (w_state_nxt == S_CRC);
         r_busy       <= (w_state_nxt != S_IDLE);
         r_done       <= (w_state_nxt == S_DONE);
      end
   end

   // Frame context, running CRC and the sticky comparison result.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_poly <= {CRC_WIDTH{1'b0}};
         r_cnt  <= {LEN_WIDTH{1'b0}};
         r_crc  <= {CRC_WIDTH{1'b0}};
         r_err  <= 1'b0;
      end else if (w_start) begin
         r_poly <= GenPoly;
         r_cnt  <= frameLen;
         r_crc  <= {CRC_WIDTH{1'b0}};
         r_err  <= 1'b0;
      end else if (w_data_acc) begin
         r_cnt  <= r_cnt - LEN_WIDTH'(1);
         r_crc  <= crc_word(r_crc, dataIn, r_poly);
      end else if (w_crc_acc) begin
         r_err  <= w_mismatch;
      end
   end

`ifdef CRC_CHECKER_ERRCNT_EN
   logic [15:0] r_err_cnt;

   // Saturating count of failed frames, visible together with checkDone.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_err_cnt <= 16'h0000;
      end else if (w_crc_acc && w_mismatch && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'h0001;
      end
   end

   assign errCnt = r_err_cnt;
`endif

   assign dataReady = r_data_ready;
   assign crcReady  = r_crc_ready;
   assign busy      = r_busy;
   assign checkDone = r_done;
   assign crcErr    = r_err;
   assign crcCalc   = r_crc;

endmodule

// File: doc/crc_checker.md
# crc_checker

- Receive-side counterpart of the parallel CRC generator.
- Accepts a frame of `frameLen` DWIDTH-bit data words, one per cycle, then the transmitted CRC.
- Recomputes the CRC with the same polynomial convention and flags mismatch.
- Sits at the receive end of a link whose transmitter appends `crcSeq` from the generator.

## Interface
- `CRC_WIDTH`, 8: CRC/remainder width.
- `DWIDTH`, 16: data word width.
- `LEN_WIDTH`, 8: frame length field width (max 2^LEN_WIDTH-1 words).
- `clk` input 1: clock, all logic on rising edge.
- `rstN` input 1: reset, asynchronous, active-low.
- `startIn` input 1: frame start request; sampled only in IDLE.
- `frameLen` input LEN_WIDTH: data word count, captured with `startIn`.
- `GenPoly` input CRC_WIDTH: generator polynomial without the implicit x^CRC_WIDTH term; captured with `startIn`.
- `dataValid` input 1 / `dataIn` input DWIDTH / `dataReady` output 1: data handshake.
- `crcValid` input 1 / `crcIn` input CRC_WIDTH / `crcReady` output 1: received-CRC handshake.
- `busy` output 1: high in any state other than IDLE.
- `checkDone` output 1: one-cycle pulse, result valid.
- `crcErr` output 1: 1 = computed CRC differs from `crcIn`; held until next accepted start.
- `crcCalc` output CRC_WIDTH: running/final computed CRC.

## Operation
- Reset value of every output is 0: `dataReady`, `crcReady`, `busy`, `checkDone`, `crcErr`, `crcCalc`, and `errCnt` when present. State is IDLE and the word counter is 0.
- IDLE, on `startIn`:
  - Capture `GenPoly` and `frameLen`, clear `crcCalc` to 0, clear `crcErr`.
  - Go to DATA, or to CRC if `frameLen`=0.
- DATA:
  - `dataReady`=1.
  - A word is accepted on `dataValid && dataReady`.
  - The accepted word updates `crcCalc` in that same edge; the counter decrements.
  - After the last word is accepted, go to CRC.
  - `dataValid` low stalls indefinitely with no state change.
- CRC:
  - `crcReady`=1.
  - On `crcValid`, register `crcErr = (crcIn != crcCalc)` and go to DONE.
- DONE: `checkDone`=1 for this single cycle, then IDLE.
- `startIn` outside IDLE is ignored, including in DONE.
- `dataValid` outside DATA and `crcValid` outside CRC are ignored; the ready signals are low there.
- Word update, MSB-first, no reflection, no final XOR. For b = DWIDTH-1 down to 0:
  - fb = crc[CRC_WIDTH-1] ^ d[b]
  - crc = {crc[CRC_WIDTH-2:0],1'b0} ^ (fb ? GenPolyReg : 0)
  - The whole word is computed combinationally in one cycle.
- For a 1-word frame, `crcCalc` equals the generator's `crcSeq` for the same data and poly.
- Asynchronous reset mid-frame aborts the frame: no `checkDone`, everything returns to reset values.

## Timing
- `startIn` at edge t puts `busy` high after t; `dataReady` is high in the following cycle.
- Frame of N words with no stalls:
  - Words are accepted at edges t+1..t+N.
  - CRC is accepted at t+N+1.
  - `checkDone` is high in the cycle after t+N+1.
  - `busy` drops at t+N+2.
- `crcCalc` is final after the last data accept and stays stable until the next start.
- Back-to-back frames: a new `startIn` is accepted in the IDLE cycle following DONE (1-cycle gap minimum).

## Configuration
- `CRC_CHECKER_ERRCNT_EN` defined:
  - Adds output `errCnt` [15:0], reset 0.
  - Increments on each `checkDone` with `crcErr`=1.
  - Saturates at 0xFFFF.
- Undefined: the `errCnt` port and its logic are absent; all other behaviour is identical.

## Test plan
- GenPoly=0x07, frameLen=1, data 0x0001, crcIn 0x07 -> `crcCalc`=0x07, `checkDone` pulse, `crcErr`=0.
- Same poly, frameLen=1, data 0x0101, crcIn 0x15 -> `crcCalc`=0x12, `crcErr`=1; `errCnt`=1 if enabled.
- frameLen=2, words 0x0001, 0x0000, with 3 idle cycles of `dataValid` between them, crcIn 0x6B -> `crcCalc`=0x6B, `crcErr`=0. Stall adds exactly 3 cycles to the done time.
- frameLen=0, crcIn 0x00 -> DATA skipped, `crcErr`=0; crcIn 0x01 -> `crcErr`=1.
- `startIn` pulsed during DATA and DONE -> ignored. `rstN` low after word 1 of a 2-word frame -> all outputs 0, no `checkDone`; next frame checks correctly.
- 0xFFFF+2 error frames with `CRC_CHECKER_ERRCNT_EN` -> `errCnt` stops at 0xFFFF.
